// File: rtl/alu_decoder_mc.sv
// ALU decoder with a multi-cycle sequencer around an iterative (1 bit/cycle) unsigned MUL/DIV unit.
// Optional macro MDU_EARLY_OUT_EN: MUL by zero and DIV by zero finish in the cycle after issue.
module alu_decoder_mc #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              alu_op,
  input  logic [5:0]        funct,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  output logic [CTRL_W-1:0] alu_control,
  output logic [1:0]        flag_w,
  output logic              stall,
  output logic              mdu_valid,
  output logic [WIDTH-1:0]  mdu_result,
  output logic              div_by_zero,
  output logic              illegal
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] C_ORR = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] C_MUL = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] C_DIV = CTRL_W'(4'b1011);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nx;

  logic [3:0]        cmd;
  logic              s_bit;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [1:0]        dec_flag;
  logic              dec_known;
  logic              dec_mdu;
  logic              dec_div;
  logic              dec_go;
  logic              zero_op;

  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  a_q, b_q, acc;
  logic [WIDTH-1:0]  a_nx, b_nx, acc_nx;
  logic [WIDTH:0]    rem_sh;
  logic              div_q, s_q, dz_q;
  logic [CTRL_W-1:0] op_ctrl;

  logic unused_funct;
  assign unused_funct = &{1'b0, funct[5]};

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  always_comb begin
    dec_ctrl  = C_ADD;
    dec_flag  = 2'b00;
    dec_known = 1'b1;
    dec_mdu   = 1'b0;
    dec_div   = 1'b0;
    case (cmd)
      4'b0100: begin dec_ctrl = C_ADD; dec_flag = s_bit ? 2'b11 : 2'b00; end
      4'b0010: begin dec_ctrl = C_SUB; dec_flag = s_bit ? 2'b11 : 2'b00; end
      4'b0000: begin dec_ctrl = C_AND; dec_flag = s_bit ? 2'b10 : 2'b00; end
      4'b1100: begin dec_ctrl = C_ORR; dec_flag = s_bit ? 2'b10 : 2'b00; end
      4'b1110: begin dec_ctrl = C_MUL; dec_flag = s_bit ? 2'b11 : 2'b00; dec_mdu = 1'b1; end
      4'b1111: begin
        dec_ctrl = C_DIV; dec_flag = s_bit ? 2'b11 : 2'b00; dec_mdu = 1'b1; dec_div = 1'b1;
      end
      default: dec_known = 1'b0;
    endcase
  end

  assign dec_go  = issue && alu_op && dec_mdu;
  assign zero_op = dec_div ? (src_b == '0) : ((src_a == '0) || (src_b == '0));
  assign op_ctrl = div_q ? C_DIV : C_MUL;

  // One iteration: MUL shifts multiplicand left / multiplier right and accumulates;
  // DIV shifts the dividend's MSB into the remainder and restores on underflow.
  assign rem_sh = {acc, a_q[WIDTH-1]};
  always_comb begin
    a_nx   = a_q;
    b_nx   = b_q;
    acc_nx = acc;
    if (div_q) begin
      if (rem_sh >= {1'b0, b_q}) begin
        acc_nx = WIDTH'(rem_sh - {1'b0, b_q});
        a_nx   = {a_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        a_nx   = {a_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx = acc + (b_q[0] ? a_q : '0);
      a_nx   = a_q << 1;
      b_nx   = b_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dec_go) begin
`ifdef MDU_EARLY_OUT_EN
          state_nx = zero_op ? DONE : BUSY;
`else
          state_nx = BUSY;
`endif
        end
      end
      BUSY:    if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      div_q      <= 1'b0;
      s_q        <= 1'b0;
      dz_q       <= 1'b0;
      mdu_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dec_go) begin
            a_q   <= src_a;
            b_q   <= src_b;
            acc   <= '0;
            cnt   <= '0;
            div_q <= dec_div;
            s_q   <= s_bit;
            dz_q  <= dec_div && (src_b == '0);
`ifdef MDU_EARLY_OUT_EN
            if (zero_op) mdu_result <= dec_div ? '1 : '0;
`endif
          end
        end
        BUSY: begin
          a_q <= a_nx;
          b_q <= b_nx;
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) mdu_result <= div_q ? a_nx : acc_nx;
        end
        default: ;
      endcase
    end
  end

  // Flag writes are deferred from the issue cycle to DONE so they line up with mdu_result.
  always_comb begin
    alu_control = C_ADD;
    flag_w      = 2'b00;
    stall       = 1'b0;
    mdu_valid   = 1'b0;
    div_by_zero = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE: begin
        if (issue && alu_op) begin
          alu_control = dec_ctrl;
          illegal     = !dec_known;
          if (dec_mdu) stall = 1'b1;
          else         flag_w = dec_flag;
        end
      end
      BUSY: begin
        alu_control = op_ctrl;
        stall       = 1'b1;
      end
      DONE: begin
        alu_control = op_ctrl;
        flag_w      = s_q ? 2'b11 : 2'b00;
        mdu_valid   = 1'b1;
        div_by_zero = dz_q;
      end
      default: ;
    endcase
  end

  logic unused_zero;
  assign unused_zero = &{1'b0, zero_op};

endmodule
